iterative_divider: RTL
======================

// Module: iterative_divider
// PURPOSE
//  Shift-and-subtract (restoring) divider; the inverse companion of the shift-and-add multiplier.
//  Computes QUOTIENT = A / B and REMAINDER = A % B over WIDTH iterations, one bit per clock.
//  Uses the same start/ready handshake as the multiplier, so both blocks share one controller pattern.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clock      in   1      master clock, all state updates on the rising edge
//  reset_n    in   1      master reset, asynchronous, active-low
//  start      in   1      request a division; sampled only while ready=1
//  A          in   WIDTH  dividend; sampled on the accepting edge
//  B          in   WIDTH  divisor; sampled on the accepting edge
//  ready      out  1      1 = idle, result valid, new start accepted
//  Q          out  WIDTH  quotient (registered, held until the next completion)
//  R          out  WIDTH  remainder (registered, held until the next completion)
//  div_zero   out  1      1 = last completed operation had B == 0
// BEHAVIOUR
//  Reset (reset_n=0, any time including mid-operation): state=IDLE, ready=1, Q=0, R=0, div_zero=0, count=0.
//  FSM states: IDLE, CALC, FIX (FIX exists only with SIGNED_DIV_EN).
//  IDLE: on an edge with start=1, the block accepts the request.
//    - B != 0: load rem_reg=0 (WIDTH+1 b), quo_reg=A, div_reg=B, count=WIDTH, ready<=0, go to CALC.
//    - B == 0: no iteration. Next edge: Q<=all ones, R<=A, div_zero<=1, ready stays 1.
//  CALC, one iteration per cycle:
//    - trial = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]} - {1'b0, div_reg}, computed at WIDTH+1 bits.
//    - trial sign bit 0: rem<=trial, quo<={quo[WIDTH-2:0],1}; otherwise restore: rem<=shifted rem, quo<={quo,0}.
//    - count decrements; on the edge where count goes 1->0: Q<=quo, R<=rem, div_zero<=0, ready<=1, IDLE.
//  Latency (unsigned): ready low for exactly WIDTH cycles; Q/R update on the same edge that ready rises.
//  start while ready=0 is ignored (no queueing). start held high in IDLE re-triggers on every accepting edge.
//  Q/R/div_zero never change except on completion or reset; A/B may change freely after acceptance.
//  Edge cases: A < B -> Q=0, R=A. B=1 -> Q=A, R=0. A=B -> Q=1, R=0. A=0 -> Q=0, R=0.
// CONFIGURATION
//  SIGNED_DIV_EN defined: A, B are two's complement. On acceptance, magnitudes are loaded and
//    sign_q=A[MSB]^B[MSB] and sign_r=A[MSB] are latched. After CALC, one extra FIX cycle negates
//    quo/rem per the latched signs. The quotient truncates toward zero; the remainder takes the sign of A.
//    ready stays low for WIDTH+1 cycles. Most-negative / -1 yields Q=most-negative, R=0 (wraps, no flag).
//    On B==0: Q=all ones, R=A, exactly as in unsigned mode.
//  SIGNED_DIV_EN undefined: unsigned only; no FIX state, no sign logic.
// STRUCTURE
//  divider_pkg: state encoding localparams (IDLE/CALC/FIX, one-hot 3 bits) and a COUNT_W = $clog2(WIDTH+1) function.
//  Sub-module div_step (combinational): inputs rem, quo MSB, divisor -> next rem, quotient bit. Holds the
//    WIDTH+1 bit subtract/restore logic so that the FSM and datapath registers stay in iterative_divider.
// TESTING
//  1. Reset pulse mid-CALC (A=100, B=7, after 5 cycles) -> ready=1, Q=0, R=0, div_zero=0 immediately.
//  2. A=100, B=7 -> ready low exactly 32 cycles, then Q=14, R=2, div_zero=0.
//  3. A=32'hFFFFFFFF, B=1 -> Q=32'hFFFFFFFF, R=0; then A=5, B=9 -> Q=0, R=5.
//  4. A=1234, B=0 -> ready never drops, next edge Q=32'hFFFFFFFF, R=1234, div_zero=1.
//  5. start pulsed during CALC with different A/B -> ignored; result matches the first operands only.
//  6. SIGNED_DIV_EN: A=-7, B=2 -> Q=-3, R=-1, ready low 33 cycles; A=32'h80000000, B=-1 -> Q=32'h80000000, R=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: one-hot FSM encoding and counter sizing.
package divider_pkg;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_CALC = 3'b010;
  localparam logic [2:0] ST_FIX  = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_e;

  // The iteration counter must be able to hold the value WIDTH itself.
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always zero here.
  assign unused_rem_msb = rem_i[WIDTH];

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], quo_msb_i};
    trial   = shifted - {1'b0, div_i};
    q_bit_o = ~trial[WIDTH];
    rem_o   = trial[WIDTH] ? shifted : trial;
  end

endmodule

// File: rtl/iterative_divider.sv
// Shift-and-subtract divider, one quotient bit per clock, start/ready handshake.
// Define SIGNED_DIV_EN for two's complement operands (adds a sign-fix cycle).
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero,
  output state_e           dbg_state
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1.
  // ready=1 also means Q/R/div_zero hold the most recent completed result.

  localparam int CW = count_w(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_d;
  logic             q_bit_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_DIV_EN
  logic sign_q_q;
  logic sign_r_q;

  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
  end
`else
  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_msb_i (quo_q[WIDTH-1]),
    .div_i     (div_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  assign dbg_state = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      ready    <= 1'b1;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (B == '0) begin
              Q        <= '1;
              R        <= A;
              div_zero <= 1'b1;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              div_q   <= b_mag;
              cnt_q   <= CW'(WIDTH);
              ready   <= 1'b0;
              state_q <= CALC;
`ifdef SIGNED_DIV_EN
              sign_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r_q <= A[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], q_bit_d};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            Q        <= {quo_q[WIDTH-2:0], q_bit_d};
            R        <= rem_d[WIDTH-1:0];
            div_zero <= 1'b0;
            ready    <= 1'b1;
            state_q  <= IDLE;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        FIX: begin
          Q        <= sign_q_q ? -quo_q : quo_q;
          R        <= sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          div_zero <= 1'b0;
          ready    <= 1'b1;
          state_q  <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
